// File: rtl/ram_scan_reader.sv
// Read-side scan sequencer for the pushbutton-loaded RAM: walks addresses by dwell timer or single step,
// captures each word for the display and can stop on a data match.
module ram_scan_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DWELL  = 250
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              run,
  input  logic              step,
  input  logic              match_en,
  input  logic [DATA_W-1:0] match_val,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              halted,
  output logic              wrap
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {RD, CAP, IDLE} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] data_out_reg, data_out_next;
  logic              data_valid_reg, data_valid_next;
  logic              halted_reg, halted_next;
  logic              wrap_reg, wrap_next;
  logic [CNT_W-1:0]  dwell_cnt_reg, dwell_cnt_next;

  logic              run_tick;
  logic              advance;

  // A halted scan ignores the dwell timer entirely; only a step moves it on.
  assign run_tick = run && !halted_reg && tick;
  assign advance  = step || (run_tick && (dwell_cnt_reg == DWELL_LAST));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= RD;
      addr_reg       <= '0;
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
      halted_reg     <= 1'b0;
      wrap_reg       <= 1'b0;
      dwell_cnt_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      data_out_reg   <= data_out_next;
      data_valid_reg <= data_valid_next;
      halted_reg     <= halted_next;
      wrap_reg       <= wrap_next;
      dwell_cnt_reg  <= dwell_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    data_out_next   = data_out_reg;
    data_valid_next = 1'b0;
    halted_next     = halted_reg;
    wrap_next       = 1'b0;
    dwell_cnt_next  = dwell_cnt_reg;

    unique case (state_reg)
      RD: begin
        state_next = CAP;
      end
      CAP: begin
        data_out_next   = ram_dout;
        data_valid_next = 1'b1;
        dwell_cnt_next  = '0;
        if (match_en && (ram_dout == match_val)) begin
          halted_next = 1'b1;
        end
        state_next = IDLE;
      end
      IDLE: begin
        if (advance) begin
          addr_next      = addr_reg + ADDR_W'(1);
          wrap_next      = &addr_reg;
          halted_next    = 1'b0;
          dwell_cnt_next = '0;
          state_next     = RD;
        end else if (run_tick) begin
          dwell_cnt_next = dwell_cnt_reg + CNT_W'(1);
        end else if (!run) begin
          dwell_cnt_next = '0;
        end
      end
      default: begin
        state_next = RD;
      end
    endcase
  end

  assign addr       = addr_reg;
  assign data_out   = data_out_reg;
  assign data_valid = data_valid_reg;
  assign halted     = halted_reg;
  assign wrap       = wrap_reg;

endmodule

// File: tb/tb_ram_scan_reader.sv
// Bench for ram_scan_reader: a registered-read RAM, a phase-based reference model compared every cycle,
// and directed scenarios with hand-computed expectations.
module tb_ram_scan_reader;

  localparam int DW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic        run;
  logic        step;
  logic        match_en;
  logic [15:0] match_val;
  logic [15:0] ram_dout;
  logic [7:0]  addr;
  logic [15:0] data_out;
  logic        data_valid;
  logic        halted;
  logic        wrap;

  logic [15:0] mem [0:255];

  int compared   = 0;
  int mismatched = 0;

  ram_scan_reader #(.ADDR_W(8), .DATA_W(16), .DWELL(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .run       (run),
    .step      (step),
    .match_en  (match_en),
    .match_val (match_val),
    .ram_dout  (ram_dout),
    .addr      (addr),
    .data_out  (data_out),
    .data_valid(data_valid),
    .halted    (halted),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_dout <= mem[addr];

  // Reference model: settle counts the clocks until the word at the current address is captured;
  // ticks counts dwell ticks seen at this address while actively scanning.
  logic [7:0]  m_addr;
  logic [15:0] m_data;
  logic        m_valid, m_halted, m_wrap;
  int          m_settle, m_ticks;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_addr = 8'h00; m_data = 16'h0000; m_valid = 1'b0; m_halted = 1'b0; m_wrap = 1'b0;
      m_settle = 2; m_ticks = 0;
    end else begin
      m_valid = 1'b0;
      m_wrap  = 1'b0;
      if (m_settle == 2) begin
        m_settle = 1;
      end else if (m_settle == 1) begin
        m_data  = mem[m_addr];
        m_valid = 1'b1;
        if (match_en && mem[m_addr] == match_val) m_halted = 1'b1;
        m_ticks  = 0;
        m_settle = 0;
      end else if (step || (run && !m_halted && tick && m_ticks == DW - 1)) begin
        m_wrap   = (m_addr == 8'd255);
        m_addr   = m_addr + 8'd1;
        m_halted = 1'b0;
        m_ticks  = 0;
        m_settle = 2;
      end else if (run && !m_halted && tick) begin
        m_ticks = m_ticks + 1;
      end else if (!run) begin
        m_ticks = 0;
      end
    end
  end

  always @(negedge clk) begin
    compared++;
    if ({addr, data_out, data_valid, halted, wrap} !== {m_addr, m_data, m_valid, m_halted, m_wrap}) begin
      mismatched++;
      $display("FAIL model_cycle t=%0t dut addr=%h data=%h v=%b h=%b w=%b required addr=%h data=%h v=%b h=%b w=%b",
               $time, addr, data_out, data_valid, halted, wrap, m_addr, m_data, m_valid, m_halted, m_wrap);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end else begin
      $display("check %s = %h ok t=%0t", name, act, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_tick(input logic with_step);
    tick = 1'b1;
    step = with_step;
    cyc();
    tick = 1'b0;
    step = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      repeat (9) cyc();
      pulse_tick(1'b0);
    end
  endtask

  task automatic do_step();
    step = 1'b1;
    cyc();
    step = 1'b0;
    cyc();
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {8'hA5, 8'(i)};
    mem[0] = 16'h1234;
    mem[7] = 16'hBEEF;
    reset = 1'b1; tick = 1'b0; run = 1'b0; step = 1'b0; match_en = 1'b0; match_val = 16'h0000;

    // Reset release: address 0 captured two clocks later.
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    check("rst_addr", 32'(addr), 32'h0);
    check("rst_valid_early", 32'(data_valid), 32'h0);
    cyc();
    check("rst_data", 32'(data_out), 32'h1234);
    check("rst_valid", 32'(data_valid), 32'h1);
    check("rst_halted", 32'(halted), 32'h0);
    cyc();
    check("rst_valid_once", 32'(data_valid), 32'h0);

    // Single step latency.
    step = 1'b1;
    cyc();
    step = 1'b0;
    check("step_addr", 32'(addr), 32'h1);
    check("step_valid_n", 32'(data_valid), 32'h0);
    cyc();
    check("step_valid_n1", 32'(data_valid), 32'h0);
    cyc();
    check("step_data", 32'(data_out), 32'hA501);
    check("step_valid_n2", 32'(data_valid), 32'h1);
    repeat (4) do_step();
    check("five_steps", 32'(addr), 32'h5);

    // Step held across RD and CAP advances only once.
    step = 1'b1;
    repeat (3) cyc();
    step = 1'b0;
    cyc();
    cyc();
    check("step_in_rd_cap", 32'(addr), 32'h6);

    // Dwell of 4 ticks per address.
    run = 1'b1;
    run_ticks(3);
    check("dwell_not_yet", 32'(addr), 32'h6);
    run_ticks(1);
    check("dwell_advance", 32'(addr), 32'h7);

    // Step on the dwell-expiry tick: one advance only.
    run_ticks(3);
    repeat (9) cyc();
    pulse_tick(1'b1);
    check("step_plus_dwell", 32'(addr), 32'h8);
    repeat (3) cyc();
    check("step_plus_dwell_hold", 32'(addr), 32'h8);

    // Walk to 0xFE and wrap under run mode.
    run = 1'b0;
    for (int i = 0; i < 246; i++) do_step();
    check("walk_fe", 32'(addr), 32'hFE);
    run = 1'b1;
    run_ticks(4);
    check("run_ff", 32'(addr), 32'hFF);
    check("no_wrap_ff", 32'(wrap), 32'h0);
    run_ticks(3);
    repeat (9) cyc();
    pulse_tick(1'b0);
    check("wrap_addr", 32'(addr), 32'h0);
    check("wrap_pulse", 32'(wrap), 32'h1);
    match_en  = 1'b1;
    match_val = 16'hBEEF;
    cyc();
    check("wrap_one_clk", 32'(wrap), 32'h0);

    // Halt on match at address 7.
    run_ticks(28);
    check("halt_addr", 32'(addr), 32'h7);
    cyc();
    cyc();
    check("halt_flag", 32'(halted), 32'h1);
    check("halt_data", 32'(data_out), 32'hBEEF);
    run_ticks(20);
    check("halt_holds_addr", 32'(addr), 32'h7);
    match_en = 1'b0;
    cyc();
    check("halt_survives_en_low", 32'(halted), 32'h1);
    step = 1'b1;
    cyc();
    step = 1'b0;
    check("resume_addr", 32'(addr), 32'h8);
    check("resume_halted", 32'(halted), 32'h0);
    cyc();
    cyc();
    run_ticks(4);
    check("resume_scan", 32'(addr), 32'h9);

    // Asynchronous reset while in CAP at address 9.
    cyc();
    reset = 1'b1;
    #1;
    check("async_addr", 32'(addr), 32'h0);
    check("async_data", 32'(data_out), 32'h0);
    check("async_valid", 32'(data_valid), 32'h0);
    check("async_halted", 32'(halted), 32'h0);
    cyc();
    reset = 1'b0;
    cyc();
    cyc();
    check("rerst_addr", 32'(addr), 32'h0);
    check("rerst_data", 32'(data_out), 32'h1234);
    check("rerst_valid", 32'(data_valid), 32'h1);

    repeat (4) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
